writeback_unit: RTL and testbench

- Writeback stage directly upstream of the register file write port (wrAddr/wrData/wrEna).
- Merges two result sources into the single write port: the ALU result channel and the load-return channel.
- Performs load sign/zero extension and byte/halfword extraction.
- Holds one stalled ALU result in a skid buffer and drives registered write signals.

---
 rtl/wb_pkg.sv | 10 +
 rtl/load_extend.sv | 24 ++
 rtl/writeback_unit.sv | 101 ++++++++++
 tb/tb_writeback_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared load funct3 codes, skid-buffer state encoding and default address width
package wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic {WB_EMPTY = 1'b0, WB_FULL = 1'b1} wb_state_e;
endpackage

// File: rtl/load_extend.sv
// load_extend: byte/halfword extraction and sign/zero extension of an aligned load word
module load_extend
  import wb_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic [REG_WIDTH-1:0] mem_data,
  input  logic [2:0]           funct3,
  input  logic [1:0]           byte_off,
  output logic [REG_WIDTH-1:0] ext_data
);
  logic [7:0]  b;
  logic [15:0] h;
  // pick the addressed byte/halfword, then extend by funct3; unknown codes fall through to LW
  always_comb begin
    b        = mem_data[{byte_off, 3'b000} +: 8];
    h        = byte_off[1] ? mem_data[31:16] : mem_data[15:0];
    ext_data = funct3 == F3_LB  ? {{(REG_WIDTH-8){b[7]}}, b}   :
               funct3 == F3_LBU ? {{(REG_WIDTH-8){1'b0}}, b}   :
               funct3 == F3_LH  ? {{(REG_WIDTH-16){h[15]}}, h} :
               funct3 == F3_LHU ? {{(REG_WIDTH-16){1'b0}}, h}  :
                                  mem_data;
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results onto the register file write port; optional WB_BYPASS_EN adds in-flight write forwarding
module writeback_unit
  import wb_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = WB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluRd,
  input  logic [REG_WIDTH-1:0]  aluData,
  input  logic                  memValid,
  input  logic [ADDR_WIDTH-1:0] memRd,
  input  logic [REG_WIDTH-1:0]  memData,
  input  logic [2:0]            memFunct3,
  input  logic [1:0]            memByteOff,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [REG_WIDTH-1:0]  wrData,
  output logic                  wrEna,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] rdAddr0,
  input  logic [ADDR_WIDTH-1:0] rdAddr1,
  output logic                  fwdHit0,
  output logic                  fwdHit1,
  output logic [REG_WIDTH-1:0]  fwdData0,
  output logic [REG_WIDTH-1:0]  fwdData1,
`endif
  output logic                  busy
);
  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] skid_rd, issue_rd;
  logic [REG_WIDTH-1:0]  skid_data, issue_data, ld_data;
  logic                  issue_v, skid_ld;

  load_extend #(.REG_WIDTH(REG_WIDTH)) u_ext (
    .mem_data (memData),
    .funct3   (memFunct3),
    .byte_off (memByteOff),
    .ext_data (ld_data)
  );

  assign aluReady = state_q == WB_EMPTY;
  assign busy     = state_q == WB_FULL;

  // arbitration: loads win; a colliding ALU result parks in the skid buffer and drains on the next load-free cycle
  always_comb begin
    state_d    = state_q;
    issue_v    = 1'b0;
    issue_rd   = aluRd;
    issue_data = aluData;
    skid_ld    = 1'b0;
    if (memValid) begin
      issue_v    = 1'b1;
      issue_rd   = memRd;
      issue_data = ld_data;
      if (state_q == WB_EMPTY && aluValid) begin
        skid_ld = 1'b1;
        state_d = WB_FULL;
      end
    end else if (state_q == WB_FULL) begin
      issue_v    = 1'b1;
      issue_rd   = skid_rd;
      issue_data = skid_data;
      state_d    = WB_EMPTY;
    end else if (aluValid) begin
      issue_v = 1'b1;
    end
  end

  // state, skid entry and registered write port; x0 writes consume the slot but never assert wrEna
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WB_EMPTY;
      skid_rd   <= '0;
      skid_data <= '0;
      wrAddr    <= '0;
      wrData    <= '0;
      wrEna     <= 1'b0;
    end else begin
      state_q <= state_d;
      wrEna   <= issue_v && (issue_rd != '0);
      if (issue_v) begin
        wrAddr <= issue_rd;
        wrData <= issue_data;
      end
      if (skid_ld) begin
        skid_rd   <= aluRd;
        skid_data <= aluData;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwdHit0  = wrEna && (wrAddr == rdAddr0) && (rdAddr0 != '0);
  assign fwdHit1  = wrEna && (wrAddr == rdAddr1) && (rdAddr1 != '0);
  assign fwdData0 = wrData;
  assign fwdData1 = wrData;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench for writeback_unit (expected writes queued at drive time, popped at wrEna)
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aluValid = 1'b0, memValid = 1'b0;
  logic        aluReady, wrEna, busy;
  logic [4:0]  aluRd = '0, memRd = '0, wrAddr;
  logic [31:0] aluData = '0, memData = '0, wrData;
  logic [2:0]  memFunct3 = '0;
  logic [1:0]  memByteOff = '0;
`ifdef WB_BYPASS_EN
  logic [4:0]  rdAddr0 = '0, rdAddr1 = '0;
  logic        fwdHit0, fwdHit1;
  logic [31:0] fwdData0, fwdData1;
`endif
  int n_vec = 0, n_err = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
    .memValid(memValid), .memRd(memRd), .memData(memData),
    .memFunct3(memFunct3), .memByteOff(memByteOff),
    .wrAddr(wrAddr), .wrData(wrData), .wrEna(wrEna),
`ifdef WB_BYPASS_EN
    .rdAddr0(rdAddr0), .rdAddr1(rdAddr1), .fwdHit0(fwdHit0), .fwdHit1(fwdHit1),
    .fwdData0(fwdData0), .fwdData1(fwdData1),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
    aluValid = 1'b1; aluRd = rd; aluData = d;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    memValid = 1'b1; memRd = rd; memFunct3 = f3; memByteOff = off; memData = d;
  endtask

  task automatic idle_in();
    aluValid = 1'b0; memValid = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    if (rd != 0) exp_q.push_back({rd, d});
  endtask

  // every asserted write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && wrEna) begin
      if (exp_q.size() == 0) chk("spurious_wr", 32'd1, 32'd0);
      else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, wrAddr}, {27'd0, e[36:32]});
        chk("wr_data", wrData, e[31:0]);
      end
    end
  end

  typedef struct { logic [2:0] f3; logic [1:0] off; logic [31:0] exp; } ext_t;
  ext_t ext_tab[10];

  initial begin
    ext_tab[0] = '{3'b000, 2'd3, 32'hFFFFFF80};
    ext_tab[1] = '{3'b100, 2'd3, 32'h00000080};
    ext_tab[2] = '{3'b001, 2'd2, 32'hFFFF80FF};
    ext_tab[3] = '{3'b101, 2'd0, 32'h00007F01};
    ext_tab[4] = '{3'b000, 2'd1, 32'h0000007F};
    ext_tab[5] = '{3'b000, 2'd2, 32'hFFFFFFFF};
    ext_tab[6] = '{3'b100, 2'd2, 32'h000000FF};
    ext_tab[7] = '{3'b001, 2'd3, 32'hFFFF80FF};
    ext_tab[8] = '{3'b010, 2'd1, 32'h80FF7F01};
    ext_tab[9] = '{3'b011, 2'd2, 32'h80FF7F01};

    repeat (2) step();
    chk("rst_wrena", {31'd0, wrEna}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wraddr", {27'd0, wrAddr}, 32'd0);
    chk("rst_wrdata", wrData, 32'd0);
    rst = 1'b1;
    step();

    // reset while FULL: load drains, held ALU entry is dropped
    set_mem(5'd3, 3'b010, 2'd0, 32'h11112222);
    set_alu(5'd9, 32'h99);
    expect_wr(5'd3, 32'h11112222);
    step();
    idle_in();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    chk("async_rst_wrena", {31'd0, wrEna}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("post_rst_wrena", {31'd0, wrEna}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ready", {31'd0, aluReady}, 32'd1);

    // single ALU write, one-cycle pulse
    set_alu(5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    idle_in();
    chk("alu_wrena", {31'd0, wrEna}, 32'd1);
    step();
    chk("alu_wrena_drop", {31'd0, wrEna}, 32'd0);

    // collision: load first, ALU drains next cycle
    set_mem(5'd3, 3'b010, 2'd0, 32'h11112222);
    set_alu(5'd4, 32'h55);
    expect_wr(5'd3, 32'h11112222);
    expect_wr(5'd4, 32'h55);
    step();
    idle_in();
    chk("col_busy", {31'd0, busy}, 32'd1);
    chk("col_ready", {31'd0, aluReady}, 32'd0);
    step();
    chk("col_drain_busy", {31'd0, busy}, 32'd0);
    chk("col_drain_ready", {31'd0, aluReady}, 32'd1);
    step();

    // back-to-back loads while FULL, with a second ALU result waiting on aluReady
    set_mem(5'd10, 3'b010, 2'd0, 32'hA0A0A0A0);
    set_alu(5'd11, 32'hB1);
    expect_wr(5'd10, 32'hA0A0A0A0);
    expect_wr(5'd12, 32'hC2C2C2C2);
    expect_wr(5'd11, 32'hB1);
    expect_wr(5'd13, 32'hD3);
    step();
    set_mem(5'd12, 3'b010, 2'd0, 32'hC2C2C2C2);
    set_alu(5'd13, 32'hD3);
    step();
    chk("full_stay_busy", {31'd0, busy}, 32'd1);
    memValid = 1'b0;
    step();
    chk("full_drain_busy", {31'd0, busy}, 32'd0);
    step();
    idle_in();
    step();

    // load extension table
    foreach (ext_tab[i]) begin
      set_mem(5'(16 + i), ext_tab[i].f3, ext_tab[i].off, 32'h80FF7F01);
      expect_wr(5'(16 + i), ext_tab[i].exp);
      step();
    end
    idle_in();
    step();

    // x0 writes: accepted, never enabled
    set_alu(5'd0, 32'h1234);
    step();
    idle_in();
    chk("x0_wrena", {31'd0, wrEna}, 32'd0);
    chk("x0_busy", {31'd0, busy}, 32'd0);
    set_mem(5'd6, 3'b010, 2'd0, 32'h66);
    set_alu(5'd0, 32'h77);
    expect_wr(5'd6, 32'h66);
    step();
    idle_in();
    chk("x0_skid_busy", {31'd0, busy}, 32'd1);
    step();
    chk("x0_skid_wrena", {31'd0, wrEna}, 32'd0);
    chk("x0_skid_ready", {31'd0, aluReady}, 32'd1);

`ifdef WB_BYPASS_EN
    set_alu(5'd7, 32'hCAFE0007);
    expect_wr(5'd7, 32'hCAFE0007);
    rdAddr0 = 5'd7;
    rdAddr1 = 5'd0;
    step();
    idle_in();
    chk("fwd_hit0", {31'd0, fwdHit0}, 32'd1);
    chk("fwd_data0", fwdData0, 32'hCAFE0007);
    chk("fwd_hit1", {31'd0, fwdHit1}, 32'd0);
    step();
    chk("fwd_hit0_idle", {31'd0, fwdHit0}, 32'd0);
`endif

    repeat (3) step();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
